// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions for the MEM stage: field widths, FSM encoding
// and the registered writeback bundle handed to WB.
package mem_access_pkg;

  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int TIMER_W = 8;   // wide enough for any TIMEOUT up to 255

  // FSM encoding kept as plain constants so older netlists still match.
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_WAIT = 1'b1;

  // Everything the WB stage sees, registered as one unit.
  typedef struct packed {
    logic             valid;
    logic             regWrite;
    logic             memtoreg;
    logic [REG_W-1:0] writeReg;
    logic [XLEN-1:0]  aluResult;
    logic [XLEN-1:0]  readData;
    logic             alignFault;
    logic             busFault;
  } wbBundle_t;

  // Word accesses only: the two low address bits must be clear.
  function automatic logic isAligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_timer.sv
// mem_wait_timer: clearable up-counter that flags the last permitted wait
// cycle. It parks on the terminal value instead of wrapping.
module mem_wait_timer
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // Count wait cycles; clear takes priority so a new access always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Issues word loads/stores on a
// req/ready bus with a bounded wait, stalls upstream while the access is
// outstanding, and registers the writeback bundle for WB.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  data_addr,
  input  logic [XLEN-1:0]  write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             memtoreg,
  input  logic [REG_W-1:0] write_reg,
  output logic             stall_out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_write_reg,
  output logic [XLEN-1:0]  wb_alu_result,
  output logic [XLEN-1:0]  wb_read_data,
  output logic             wb_align_fault,
  output logic             wb_bus_fault
);

  logic [0:0]       state;
  logic             access;
  logic             aligned;
  logic             inWait;
  logic             startAccess;
  logic             timerTerminal;
  logic             timeoutHit;

  // Access context captured on entry to WAIT; the bus is driven only from these.
  logic [XLEN-1:0]  addrQ;
  logic [XLEN-1:0]  wdataQ;
  logic             weQ;
  logic             regWriteQ;
  logic             memtoregQ;
  logic [REG_W-1:0] writeRegQ;

  wbBundle_t        wbNext;
  wbBundle_t        wbQ;

  assign access      = valid_in & (mem_read | mem_write);
  assign aligned     = isAligned(data_addr);
  assign inWait      = (state == STATE_WAIT);
  assign startAccess = !inWait & access & aligned;
  assign timeoutHit  = inWait & timerTerminal;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (startAccess),
    .enable  (inWait & !dmem_ready),
    .terminal(timerTerminal)
  );

  // Hold upstream while an access is being launched or still pending. Gated by
  // rst_n because the inputs may still present a live access during reset.
  assign stall_out = rst_n & (startAccess | (inWait & !dmem_ready & !timeoutHit));

  // Bus outputs come only from the latched context and are zero outside WAIT.
  assign dmem_req   = inWait;
  assign dmem_we    = inWait & weQ;
  assign dmem_addr  = inWait ? {addrQ[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = inWait ? wdataQ : '0;

  // FSM and access-context capture; a store wins when both read and write are set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STATE_IDLE;
      addrQ     <= '0;
      wdataQ    <= '0;
      weQ       <= 1'b0;
      regWriteQ <= 1'b0;
      memtoregQ <= 1'b0;
      writeRegQ <= '0;
    end else if (startAccess) begin
      state     <= STATE_WAIT;
      addrQ     <= data_addr;
      wdataQ    <= write_data;
      weQ       <= mem_write;
      regWriteQ <= reg_write;
      memtoregQ <= memtoreg;
      writeRegQ <= write_reg;
    end else if (inWait && (dmem_ready || timeoutHit)) begin
      state <= STATE_IDLE;
    end
  end

  // Next writeback bundle; ready on the final wait cycle beats the timeout.
  always_comb begin
    // NOTE: a full default first means every path assigns every field, so no
    // latch can be inferred.
    wbNext = '0;
    if (inWait) begin
      if (dmem_ready) begin
        wbNext.valid     = 1'b1;
        wbNext.regWrite  = regWriteQ;
        wbNext.memtoreg  = memtoregQ;
        wbNext.writeReg  = writeRegQ;
        wbNext.aluResult = addrQ;
        wbNext.readData  = weQ ? '0 : dmem_rdata;
      end else if (timeoutHit) begin
        wbNext.valid     = 1'b1;
        wbNext.memtoreg  = memtoregQ;
        wbNext.writeReg  = writeRegQ;
        wbNext.aluResult = addrQ;
        wbNext.busFault  = 1'b1;
      end
    end else if (valid_in && !startAccess) begin
      wbNext.valid      = 1'b1;
      wbNext.regWrite   = reg_write & !access;
      wbNext.memtoreg   = memtoreg;
      wbNext.writeReg   = write_reg;
      wbNext.aluResult  = data_addr;
      wbNext.alignFault = access;
    end
  end

  // MEM/WB boundary register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbQ <= '0;
    end else begin
      wbQ <= wbNext;
    end
  end

  assign wb_valid       = wbQ.valid;
  assign wb_reg_write   = wbQ.regWrite;
  assign wb_memtoreg    = wbQ.memtoreg;
  assign wb_write_reg   = wbQ.writeReg;
  assign wb_alu_result  = wbQ.aluResult;
  assign wb_read_data   = wbQ.readData;
  assign wb_align_fault = wbQ.alignFault;
  assign wb_bus_fault   = wbQ.busFault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: the bench acts as the data bus and memory,
// predicting each writeback from the stage's transaction-level rules.
module tb_mem_access_stage;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        memtoreg;
  logic [4:0]  write_reg;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_memtoreg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic        wb_align_fault;
  logic        wb_bus_fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] memModel [0:255];

  mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .data_addr     (data_addr),
    .write_data    (write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .memtoreg      (memtoreg),
    .write_reg     (write_reg),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_memtoreg   (wb_memtoreg),
    .wb_write_reg  (wb_write_reg),
    .wb_alu_result (wb_alu_result),
    .wb_read_data  (wb_read_data),
    .wb_align_fault(wb_align_fault),
    .wb_bus_fault  (wb_bus_fault)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    valid_in   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    memtoreg   = 1'b0;
    write_reg  = '0;
    data_addr  = '0;
    write_data = '0;
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
  endtask

  // One instruction through the stage. latency = WAIT cycles without ready
  // before the bus answers; the answer only counts inside the timeout window.
  task automatic run_op(input string tag, input logic v, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rw, input logic m2r, input logic [4:0] wreg,
                        input int latency);
    logic        isAccess, isAligned, isStore, fault;
    int          waitCycles, stallCycles, expStall;
    logic [31:0] expRead;
    logic [31:0] word;

    isAccess  = v & (rd | wr);
    isAligned = (addr[1:0] == 2'b00);
    isStore   = wr;
    fault     = 1'b0;
    expRead   = '0;
    waitCycles = 0;
    stallCycles = 0;

    @(posedge clk); #1;
    valid_in = v; mem_read = rd; mem_write = wr; data_addr = addr; write_data = wdata;
    reg_write = rw; memtoreg = m2r; write_reg = wreg; dmem_ready = 1'b0; dmem_rdata = $urandom;

    @(negedge clk);
    if (stall_out === 1'b1) stallCycles++;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL %s req_before_wait: got %0b want 0", tag, dmem_req);
    end
    @(posedge clk); #1;

    if (isAccess && isAligned) begin
      fault      = (latency + 1 > TB_TIMEOUT);
      waitCycles = fault ? TB_TIMEOUT : latency + 1;
      for (int i = 1; i <= waitCycles; i++) begin
        dmem_ready = (i == latency + 1);
        word       = memModel[addr[9:2]];
        dmem_rdata = (dmem_ready && !isStore) ? word : $urandom;
        @(negedge clk);
        if (stall_out === 1'b1) stallCycles++;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== isStore || dmem_addr !== addr) begin
          errors++;
          $display("FAIL %s bus_cycle%0d: got req=%0b we=%0b addr=%h want req=1 we=%0b addr=%h",
                   tag, i, dmem_req, dmem_we, dmem_addr, isStore, addr);
        end
        if (isStore) begin
          checks++;
          if (dmem_wdata !== wdata) begin
            errors++; $display("FAIL %s wdata_cycle%0d: got %h want %h", tag, i, dmem_wdata, wdata);
          end
        end
        checks++;
        if (wb_valid !== 1'b0) begin
          errors++; $display("FAIL %s wb_valid_in_wait: got %0b want 0", tag, wb_valid);
        end
        @(posedge clk); #1;
      end
      if (!fault && !isStore) expRead = memModel[addr[9:2]];
      if (!fault && isStore)  memModel[addr[9:2]] = wdata;
    end
    drive_idle();

    @(negedge clk);
    expStall = (isAccess && isAligned) ? waitCycles : 0;
    checks++;
    if (stallCycles != expStall) begin
      errors++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stallCycles, expStall);
    end
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 32'h0) begin
      errors++; $display("FAIL %s bus_after: got req=%0b we=%0b addr=%h want all 0", tag, dmem_req, dmem_we, dmem_addr);
    end
    checks++;
    if (wb_valid !== v) begin
      errors++; $display("FAIL %s wb_valid: got %0b want %0b", tag, wb_valid, v);
    end
    if (v) begin
      checks++;
      if (wb_reg_write !== ((fault || (isAccess && !isAligned)) ? 1'b0 : rw)) begin
        errors++; $display("FAIL %s wb_reg_write: got %0b (rw=%0b fault=%0b)", tag, wb_reg_write, rw, fault);
      end
      checks++;
      if (wb_memtoreg !== m2r || wb_write_reg !== wreg || wb_alu_result !== addr) begin
        errors++;
        $display("FAIL %s wb_fields: got m2r=%0b reg=%0d alu=%h want m2r=%0b reg=%0d alu=%h",
                 tag, wb_memtoreg, wb_write_reg, wb_alu_result, m2r, wreg, addr);
      end
      checks++;
      if (wb_read_data !== expRead) begin
        errors++; $display("FAIL %s wb_read_data: got %h want %h", tag, wb_read_data, expRead);
      end
      checks++;
      if (wb_align_fault !== (isAccess && !isAligned) || wb_bus_fault !== fault) begin
        errors++;
        $display("FAIL %s faults: got align=%0b bus=%0b want align=%0b bus=%0b",
                 tag, wb_align_fault, wb_bus_fault, isAccess && !isAligned, fault);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    valid_in = 1'b1; mem_read = 1'b1; data_addr = 32'h100;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_memtoreg,
         wb_write_reg, wb_alu_result, wb_read_data, wb_align_fault, wb_bus_fault} !== '0) begin
      errors++; $display("FAIL reset_outputs: got stall=%0b req=%0b wb_valid=%0b want all 0", stall_out, dmem_req, wb_valid);
    end
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    run_op("idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 0);
  endtask

  task automatic test_pass_through();
    run_op("pass", 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 5'd7, 0);
  endtask

  task automatic test_zero_wait_load();
    memModel[32'h100 >> 2] = 32'hDEAD_BEEF;
    run_op("load0", 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd9, 0);
  endtask

  task automatic test_wait_store();
    run_op("store3", 1'b1, 1'b0, 1'b1, 32'h200, 32'h55AA_55AA, 1'b0, 1'b0, 5'd0, 3);
    run_op("load_back", 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 5'd4, 1);
  endtask

  task automatic test_misaligned();
    run_op("misalign", 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 5'd5, 0);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b1, 1'b1, 1'b0, 32'h180, 32'h0, 1'b1, 1'b1, 5'd6, 100);
    run_op("ready_last", 1'b1, 1'b1, 1'b0, 32'h180, 32'h0, 1'b1, 1'b1, 5'd6, TB_TIMEOUT - 1);
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b1; data_addr = 32'h300; reg_write = 1'b1; write_reg = 5'd3;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre: got req=%0b want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write,
         wb_align_fault, wb_bus_fault} !== '0) begin
      errors++; $display("FAIL rst_wait_outputs: got stall=%0b req=%0b addr=%h want all 0", stall_out, dmem_req, dmem_addr);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 5'd3, 1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      addr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_op("rand", ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), addr, $urandom,
             1'($urandom), 1'($urandom), 5'($urandom), $urandom_range(0, 5));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memModel[i] = $urandom;
    test_reset();
    test_idle();
    test_pass_through();
    test_zero_wait_load();
    test_wait_store();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
